reg_bank_sb: RTL and testbench

Parametrised register bank for the multicycle/pipelined processor datapath. It holds 2^ADDR_W registers; the highest-numbered register is the program counter (PC), which has its own increment logic. The bank has two combinational read ports and one synchronous write port. New over the previous generation: width/depth parameters, optional hardwired-zero R0, optional write-to-read bypass, dedicated PC output, and a per-register pending-write scoreboard for hazard detection.

---
 rtl/reg_bank_sb.sv | 130 +++++++++++++
 tb/tb_reg_bank_sb.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: parametrised register bank. The top register is the PC, which
// has its own increment logic. The bank has two combinational read ports with
// optional write bypass, and a pending-write scoreboard for hazard detection.

// One read port: selects a register and its pending bit, then applies the
// zeroed-R0 and same-cycle write forwarding overrides.
module reg_bank_sb_rdport #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 0
) (
   input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs_i,
   input  logic [(1<<ADDR_W)-1:0]             pend_i,
   input  logic [ADDR_W-1:0]                  addr_i,
   input  logic                               wr_en_i,
   input  logic [ADDR_W-1:0]                  wr_addr_i,
   input  logic [DATA_W-1:0]                  wr_data_i,
   output logic [DATA_W-1:0]                  data_o,
   output logic                               pend_o
);
   // Register select, then R0 zeroing, then forwarding of an effective write.
   always_comb begin
      data_o = regs_i[addr_i];
      pend_o = pend_i[addr_i];
      if ((ZERO_R0 != 0) && (addr_i == '0)) begin
         data_o = '0;
         pend_o = 1'b0;
      end
      if ((BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i)) begin
         data_o = wr_data_i;
         pend_o = 1'b0;
      end
   end
endmodule

module reg_bank_sb #(
   parameter int                   DATA_W   = 16,
   parameter int                   ADDR_W   = 3,
   parameter int unsigned          PC_STEP  = 1,
   parameter logic [DATA_W-1:0]    PC_RESET = '0,
   parameter int                   ZERO_R0  = 0,
   parameter int                   BYPASS   = 0
) (
   input  logic              p_Clock,
   input  logic              p_Resetn,
   input  logic              p_IncPC,
   input  logic              p_EnableWrite,
   input  logic [ADDR_W-1:0] p_WriteAddr,
   input  logic [DATA_W-1:0] p_DataIn,
   input  logic [ADDR_W-1:0] p_ReadAddr1,
   input  logic [ADDR_W-1:0] p_ReadAddr2,
   output logic [DATA_W-1:0] p_DataOut1,
   output logic [DATA_W-1:0] p_DataOut2,
   output logic [DATA_W-1:0] p_PC,
   input  logic              p_SetPend,
   input  logic [ADDR_W-1:0] p_PendAddr,
   output logic              p_Pend1,
   output logic              p_Pend2
);
   localparam int                NREGS   = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(NREGS - 1);
   localparam logic [DATA_W-1:0] PC_INC  = DATA_W'(PC_STEP);
   localparam int                NRD     = 2;

   logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [NREGS-1:0]             pend_q, pend_d;
   logic                         wr_ok, set_ok;

   // A write or set aimed at a hardwired-zero R0 is dropped entirely.
   assign wr_ok  = p_EnableWrite && !((ZERO_R0 != 0) && (p_WriteAddr == '0));
   assign set_ok = p_SetPend     && !((ZERO_R0 != 0) && (p_PendAddr  == '0));

   // Next state: a write to the PC beats an increment; a set beats a clear on the same address.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (p_IncPC && !(wr_ok && (p_WriteAddr == PC_ADDR)))
         regs_d[PC_ADDR] = regs_q[PC_ADDR] + PC_INC;
      if (wr_ok) begin
         regs_d[p_WriteAddr] = p_DataIn;
         pend_d[p_WriteAddr] = 1'b0;
      end
      if (set_ok)
         pend_d[p_PendAddr] = 1'b1;
   end

   // State registers. Reset discards any in-flight write or increment.
   always_ff @(posedge p_Clock or negedge p_Resetn) begin
      if (!p_Resetn) begin
         regs_q          <= '0;
         regs_q[PC_ADDR] <= PC_RESET;
         pend_q          <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   assign p_PC = regs_q[PC_ADDR];

   logic [NRD-1:0][ADDR_W-1:0] rd_addr;
   logic [NRD-1:0][DATA_W-1:0] rd_data;
   logic [NRD-1:0]             rd_pend;

   assign rd_addr = {p_ReadAddr2, p_ReadAddr1};

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      reg_bank_sb_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .ZERO_R0(ZERO_R0),
         .BYPASS (BYPASS)
      ) u_rd (
         .regs_i   (regs_q),
         .pend_i   (pend_q),
         .addr_i   (rd_addr[g]),
         .wr_en_i  (wr_ok),
         .wr_addr_i(p_WriteAddr),
         .wr_data_i(p_DataIn),
         .data_o   (rd_data[g]),
         .pend_o   (rd_pend[g])
      );
   end

   assign p_DataOut1 = rd_data[0];
   assign p_DataOut2 = rd_data[1];
   assign p_Pend1    = rd_pend[0];
   assign p_Pend2    = rd_pend[1];
endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb. Three instances are used:
//   A: 16b x 8, PC_RESET=0x10, plain reads
//   B: 16b x 8, ZERO_R0 and BYPASS enabled (shares A's inputs)
//   C: 32b x 16, PC_STEP=4
// The reference model applies the behavioural rules directly to arrays.
module tb_reg_bank_sb;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // shared inputs for A and B
   logic        inc, we, sp;
   logic [2:0]  wa, ra1, ra2, paddr;
   logic [15:0] din;
   logic [15:0] a_d1, a_d2, a_pc, b_d1, b_d2, b_pc;
   logic        a_p1, a_p2, b_p1, b_p2;
   // inputs for C
   logic        c_inc, c_we, c_sp;
   logic [3:0]  c_wa, c_ra1, c_ra2, c_paddr;
   logic [31:0] c_din;
   logic [31:0] c_d1, c_d2, c_pc;
   logic        c_p1, c_p2;

   int errs = 0;
   int checks = 0;

   // reference state
   logic [15:0] ma [8];
   logic [15:0] mb [8];
   logic [31:0] mc [16];
   bit          qa [8];
   bit          qb [8];
   bit          qc [16];

   reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .PC_STEP(1), .PC_RESET(16'h0010),
                 .ZERO_R0(0), .BYPASS(0)) u_a (
      .p_Clock(clk), .p_Resetn(rst_n), .p_IncPC(inc), .p_EnableWrite(we),
      .p_WriteAddr(wa), .p_DataIn(din), .p_ReadAddr1(ra1), .p_ReadAddr2(ra2),
      .p_DataOut1(a_d1), .p_DataOut2(a_d2), .p_PC(a_pc), .p_SetPend(sp),
      .p_PendAddr(paddr), .p_Pend1(a_p1), .p_Pend2(a_p2));

   reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .PC_STEP(1), .PC_RESET(16'h0000),
                 .ZERO_R0(1), .BYPASS(1)) u_b (
      .p_Clock(clk), .p_Resetn(rst_n), .p_IncPC(inc), .p_EnableWrite(we),
      .p_WriteAddr(wa), .p_DataIn(din), .p_ReadAddr1(ra1), .p_ReadAddr2(ra2),
      .p_DataOut1(b_d1), .p_DataOut2(b_d2), .p_PC(b_pc), .p_SetPend(sp),
      .p_PendAddr(paddr), .p_Pend1(b_p1), .p_Pend2(b_p2));

   reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .PC_STEP(4), .PC_RESET(32'h0),
                 .ZERO_R0(0), .BYPASS(0)) u_c (
      .p_Clock(clk), .p_Resetn(rst_n), .p_IncPC(c_inc), .p_EnableWrite(c_we),
      .p_WriteAddr(c_wa), .p_DataIn(c_din), .p_ReadAddr1(c_ra1), .p_ReadAddr2(c_ra2),
      .p_DataOut1(c_d1), .p_DataOut2(c_d2), .p_PC(c_pc), .p_SetPend(c_sp),
      .p_PendAddr(c_paddr), .p_Pend1(c_p1), .p_Pend2(c_p2));

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin ma[i] = 0; mb[i] = 0; qa[i] = 0; qb[i] = 0; end
      for (int i = 0; i < 16; i++) begin mc[i] = 0; qc[i] = 0; end
      ma[7] = 16'h0010;
   endtask

   // expected read values given the current inputs
   function automatic logic [15:0] exp_a(input logic [2:0] a);
      return ma[a];
   endfunction
   function automatic logic [15:0] exp_b(input logic [2:0] a);
      if (a == 0) return 16'h0;
      if (we && wa == a) return din;
      return mb[a];
   endfunction
   function automatic bit exp_qb(input logic [2:0] a);
      if (a == 0) return 1'b0;
      if (we && wa == a) return 1'b0;
      return qb[a];
   endfunction

   // apply one rising edge to the model, then advance the DUTs past it
   task automatic tick();
      if (rst_n) begin
         if (we && wa == 3'd7) ma[7] = din; else if (inc) ma[7] = ma[7] + 16'd1;
         if (we && wa != 3'd7) ma[wa] = din;
         if (we) qa[wa] = 0;
         if (sp) qa[paddr] = 1;
         if (we && wa == 3'd7) mb[7] = din; else if (inc) mb[7] = mb[7] + 16'd1;
         if (we && wa != 3'd7 && wa != 3'd0) mb[wa] = din;
         if (we) qb[wa] = 0;
         if (sp && paddr != 3'd0) qb[paddr] = 1;
         if (c_we && c_wa == 4'd15) mc[15] = c_din; else if (c_inc) mc[15] = mc[15] + 32'd4;
         if (c_we && c_wa != 4'd15) mc[c_wa] = c_din;
         if (c_we) qc[c_wa] = 0;
         if (c_sp) qc[c_paddr] = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inc = 0; we = 0; sp = 0; wa = 0; ra1 = 0; ra2 = 0; paddr = 0; din = 0;
      c_inc = 0; c_we = 0; c_sp = 0; c_wa = 0; c_ra1 = 0; c_ra2 = 0; c_paddr = 0; c_din = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 8; i++) begin
         ra1 = 3'(i); ra2 = 3'(7 - i); #1;
         checks++;
         if (a_d1 !== ((i == 7) ? 16'h0010 : 16'h0)) begin
            errs++; $display("FAIL reset_a_d1[%0d] got %h exp %h", i, a_d1, ma[i]);
         end
         checks++;
         if ({a_d2, b_d1, b_d2} !== {exp_a(ra2), exp_b(ra1), exp_b(ra2)}) begin
            errs++; $display("FAIL reset_reads[%0d] got %h %h %h", i, a_d2, b_d1, b_d2);
         end
         checks++;
         if ({a_p1, a_p2, b_p1, b_p2, c_p1, c_p2} !== 6'b0) begin
            errs++; $display("FAIL reset_pend[%0d] got %b exp 0", i, {a_p1, a_p2, b_p1, b_p2, c_p1, c_p2});
         end
      end
      // writes and increments are inhibited while reset is held
      we = 1; wa = 3; din = 16'h5555; inc = 1; c_inc = 1; ra1 = 3;
      tick(); tick();
      checks++;
      if ({a_pc, b_pc, c_pc} !== {16'h0010, 16'h0, 32'h0}) begin
         errs++; $display("FAIL reset_pc got %h %h %h exp 0010 0000 00000000", a_pc, b_pc, c_pc);
      end
      checks++;
      if (a_d1 !== 16'h0) begin
         errs++; $display("FAIL reset_wr_inhibit got %h exp 0000", a_d1);
      end
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      for (int i = 1; i <= 6; i++) begin
         we = 1; wa = 3'(i); din = 16'(16'h1111 * i); ra1 = 3'(i); ra2 = 3'(i); #1;
         checks++;
         if (a_d1 !== exp_a(3'(i))) begin
            errs++; $display("FAIL wr_same_cycle_a[%0d] got %h exp %h", i, a_d1, exp_a(3'(i)));
         end
         checks++;
         if (b_d1 !== 16'(16'h1111 * i)) begin
            errs++; $display("FAIL wr_bypass_b[%0d] got %h exp %h", i, b_d1, 16'(16'h1111 * i));
         end
         tick();
         we = 0; #1;
         checks++;
         if ({a_d1, a_d2, b_d1, b_d2} !== {4{16'(16'h1111 * i)}}) begin
            errs++; $display("FAIL wr_read[%0d] got %h %h %h %h exp %h", i, a_d1, a_d2, b_d1, b_d2, 16'(16'h1111 * i));
         end
      end
      idle();
   endtask

   task automatic test_pc();
      inc = 1;
      tick(); tick(); tick();
      checks++;
      if (b_pc !== 16'd3 || a_pc !== 16'h0013) begin
         errs++; $display("FAIL pc_inc3 got %h %h exp 0013 0003", a_pc, b_pc);
      end
      we = 1; wa = 7; din = 16'hFFFF;
      tick();
      checks++;
      if (a_pc !== 16'hFFFF || b_pc !== 16'hFFFF) begin
         errs++; $display("FAIL pc_write_wins got %h %h exp ffff", a_pc, b_pc);
      end
      we = 0;
      tick();
      checks++;
      if (a_pc !== 16'h0000 || b_pc !== 16'h0000) begin
         errs++; $display("FAIL pc_wrap got %h %h exp 0000", a_pc, b_pc);
      end
      idle();
   endtask

   task automatic test_zero_bypass();
      we = 1; wa = 0; din = 16'hBEEF; ra1 = 0; ra2 = 2; #1;
      checks++;
      if (b_d1 !== 16'h0) begin
         errs++; $display("FAIL r0_no_bypass got %h exp 0000", b_d1);
      end
      tick();
      we = 0; #1;
      checks++;
      if (b_d1 !== 16'h0 || a_d1 !== 16'hBEEF) begin
         errs++; $display("FAIL r0_after_write got b=%h a=%h exp 0000 beef", b_d1, a_d1);
      end
      we = 1; wa = 2; din = 16'hABCD; ra1 = 2; #1;
      checks++;
      if (b_d1 !== 16'hABCD || a_d1 !== 16'h2222) begin
         errs++; $display("FAIL bypass_r2 got b=%h a=%h exp abcd 2222", b_d1, a_d1);
      end
      tick();
      we = 0; #1;
      checks++;
      if (b_d1 !== 16'hABCD || a_d1 !== 16'hABCD) begin
         errs++; $display("FAIL r2_after_write got b=%h a=%h exp abcd", b_d1, a_d1);
      end
      idle();
   endtask

   task automatic test_scoreboard();
      ra1 = 4; ra2 = 5;
      sp = 1; paddr = 4;
      tick();
      sp = 0; #1;
      checks++;
      if (a_p1 !== 1'b1 || b_p1 !== 1'b1) begin
         errs++; $display("FAIL sb_set got %b %b exp 1 1", a_p1, b_p1);
      end
      we = 1; wa = 4; din = 16'h4444; #1;
      checks++;
      if (a_p1 !== 1'b1 || b_p1 !== 1'b0) begin
         errs++; $display("FAIL sb_write_cycle got a=%b b=%b exp 1 0", a_p1, b_p1);
      end
      tick();
      we = 0; #1;
      checks++;
      if (a_p1 !== 1'b0 || b_p1 !== 1'b0) begin
         errs++; $display("FAIL sb_clear got %b %b exp 0 0", a_p1, b_p1);
      end
      sp = 1; paddr = 4; we = 1; wa = 4;
      tick();
      sp = 0; we = 0; #1;
      checks++;
      if (a_p1 !== 1'b1 || b_p1 !== 1'b1) begin
         errs++; $display("FAIL sb_set_wins got %b %b exp 1 1", a_p1, b_p1);
      end
      sp = 1; paddr = 5; we = 1; wa = 4;
      tick();
      sp = 0; we = 0; #1;
      checks++;
      if ({a_p1, a_p2, b_p1, b_p2} !== 4'b0101) begin
         errs++; $display("FAIL sb_diff_addr got %b exp 0101", {a_p1, a_p2, b_p1, b_p2});
      end
      ra1 = 0; sp = 1; paddr = 0;
      tick();
      sp = 0; #1;
      checks++;
      if (a_p1 !== 1'b1 || b_p1 !== 1'b0) begin
         errs++; $display("FAIL sb_r0 got a=%b b=%b exp 1 0", a_p1, b_p1);
      end
      idle();
   endtask

   task automatic test_wide();
      c_ra1 = 15; c_ra2 = 14;
      c_inc = 1;
      tick();
      checks++;
      if (c_pc !== 32'd4 || c_d1 !== 32'd4) begin
         errs++; $display("FAIL wide_pc4 got %h %h exp 4", c_pc, c_d1);
      end
      tick();
      checks++;
      if (c_pc !== 32'd8) begin
         errs++; $display("FAIL wide_pc8 got %h exp 8", c_pc);
      end
      c_inc = 0; c_we = 1; c_wa = 14; c_din = 32'hCAFE_F00D;
      tick();
      c_we = 0; #1;
      checks++;
      if (c_pc !== 32'd8 || c_d2 !== 32'hCAFE_F00D) begin
         errs++; $display("FAIL wide_r14 got pc=%h r14=%h exp 8 cafef00d", c_pc, c_d2);
      end
      c_we = 1; c_wa = 15; c_din = 32'hFFFF_FFFC; c_inc = 1;
      tick();
      c_we = 0;
      tick();
      checks++;
      if (c_pc !== 32'h0) begin
         errs++; $display("FAIL wide_wrap got %h exp 0", c_pc);
      end
      idle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         inc = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
         sp = ($urandom_range(0, 9) < 3); wa = 3'($urandom); din = 16'($urandom);
         ra1 = 3'($urandom); ra2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
         paddr = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom);
         c_inc = 1'($urandom_range(0, 1)); c_we = 1'($urandom_range(0, 1));
         c_sp = ($urandom_range(0, 9) < 3); c_wa = 4'($urandom); c_din = $urandom;
         c_ra1 = 4'($urandom); c_ra2 = 4'($urandom); c_paddr = 4'($urandom);
         #1;
         checks++;
         if ({a_d1, a_d2, a_p1, a_p2, a_pc} !== {ma[ra1], ma[ra2], qa[ra1], qa[ra2], ma[7]}) begin
            errs++; $display("FAIL rand_a[%0d] got %h %h %b %b %h exp %h %h %b %b %h", n,
                             a_d1, a_d2, a_p1, a_p2, a_pc, ma[ra1], ma[ra2], qa[ra1], qa[ra2], ma[7]);
         end
         checks++;
         if ({b_d1, b_d2, b_p1, b_p2, b_pc} !== {exp_b(ra1), exp_b(ra2), exp_qb(ra1), exp_qb(ra2), mb[7]}) begin
            errs++; $display("FAIL rand_b[%0d] got %h %h %b %b %h exp %h %h %b %b %h", n,
                             b_d1, b_d2, b_p1, b_p2, b_pc, exp_b(ra1), exp_b(ra2), exp_qb(ra1), exp_qb(ra2), mb[7]);
         end
         checks++;
         if ({c_d1, c_d2, c_p1, c_p2, c_pc} !== {mc[c_ra1], mc[c_ra2], qc[c_ra1], qc[c_ra2], mc[15]}) begin
            errs++; $display("FAIL rand_c[%0d] got %h %h %b %b %h exp %h %h %b %b %h", n,
                             c_d1, c_d2, c_p1, c_p2, c_pc, mc[c_ra1], mc[c_ra2], qc[c_ra1], qc[c_ra2], mc[15]);
         end
         tick();
      end
      idle();
   endtask

   task automatic test_async_reset();
      we = 1; wa = 3; din = 16'h1234;
      tick();
      we = 0; ra1 = 3; sp = 1; paddr = 3;
      tick();
      sp = 0; #1;
      checks++;
      if (a_d1 !== 16'h1234 || a_p1 !== 1'b1) begin
         errs++; $display("FAIL async_pre got %h %b exp 1234 1", a_d1, a_p1);
      end
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({a_d1, b_d1, a_p1, a_pc} !== {16'h0, 16'h0, 1'b0, 16'h0010}) begin
         errs++; $display("FAIL async_reset got %h %h %b %h exp 0000 0000 0 0010", a_d1, b_d1, a_p1, a_pc);
      end
      we = 1; inc = 1;
      tick();
      idle();
      rst_n = 1'b1;
      ra1 = 3;
      tick();
      checks++;
      if (a_d1 !== 16'h0 || a_pc !== 16'h0010) begin
         errs++; $display("FAIL async_release got %h %h exp 0000 0010", a_d1, a_pc);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_pc();
      test_zero_bypass();
      test_scoreboard();
      test_wide();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
